// File: rtl/calc_entry_fsm.sv
// Two-operand keypad calculator entry controller: debounced-release key commit,
// two-digit decimal operand entry, one-shot arithmetic and result chaining.
module calc_entry_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_down,
  input  logic [3:0] key_val,
  input  logic [3:0] key_sym,
  output logic [7:0] disp_val,
  output logic       neg,
  output logic       result_valid,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_RESULT  = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  localparam logic [3:0] SYM_DIGIT = 4'b1111;
  localparam logic [3:0] SYM_ADD   = 4'b0001;
  localparam logic [3:0] SYM_SUB   = 4'b0010;
  localparam logic [3:0] SYM_AND   = 4'b0011;
  localparam logic [3:0] SYM_EQ    = 4'b0100;
  localparam logic [3:0] SYM_CMP   = 4'b0101;
  localparam logic [3:0] SYM_OR    = 4'b0110;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] res_q, res_d;
  logic [3:0] op_q, op_d;
  logic [1:0] a_cnt_q, a_cnt_d;
  logic [1:0] b_cnt_q, b_cnt_d;
  logic       neg_q, neg_d;
  logic       rv_q, rv_d;
  logic       key_down_q;
  logic       armed_q;

  logic       commit;
  logic       is_digit;
  logic       is_op;
  logic       is_eq;
  logic [7:0] a_shift;
  logic [7:0] b_shift;
  logic [7:0] alu_res;

  // armed_q blocks a commit from a press already in progress when reset was released
  assign commit   = armed_q & key_down_q & ~key_down;
  assign is_digit = (key_sym == SYM_DIGIT) && (key_val <= 4'd9);
  assign is_op    = (key_sym == SYM_ADD) || (key_sym == SYM_SUB) || (key_sym == SYM_AND) ||
                    (key_sym == SYM_CMP) || (key_sym == SYM_OR);
  assign is_eq    = (key_sym == SYM_EQ);
  assign a_shift  = (a_q * 8'd10) + {4'b0000, key_val};
  assign b_shift  = (b_q * 8'd10) + {4'b0000, key_val};

  always_comb begin
    alu_res = 8'h00;
    case (op_q)
      SYM_ADD: alu_res = a_q + b_q;
      SYM_SUB: alu_res = a_q - b_q;
      SYM_AND: alu_res = a_q & b_q;
      SYM_OR:  alu_res = a_q | b_q;
      SYM_CMP: alu_res = (a_q > b_q) ? 8'h01 : ((a_q == b_q) ? 8'h00 : 8'hFF);
      default: alu_res = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ENTER_A;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      res_q      <= 8'h00;
      op_q       <= 4'h0;
      a_cnt_q    <= 2'd0;
      b_cnt_q    <= 2'd0;
      neg_q      <= 1'b0;
      rv_q       <= 1'b0;
      key_down_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      op_q       <= op_d;
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      neg_q      <= neg_d;
      rv_q       <= rv_d;
      key_down_q <= key_down;
      armed_q    <= armed_q | ~key_down;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    neg_d   = neg_q;
    rv_d    = 1'b0;
    case (state_q)
      ST_ENTER_A: begin
        if (commit) begin
          if (is_digit && (a_cnt_q != 2'd2)) begin
            a_d     = a_shift;
            a_cnt_d = a_cnt_q + 2'd1;
          end else if (is_op) begin
            op_d    = key_sym;
            if (a_cnt_q == 2'd0) a_d = 8'h00;
            b_d     = 8'h00;
            b_cnt_d = 2'd0;
            state_d = ST_ENTER_B;
          end
        end
      end
      ST_ENTER_B: begin
        if (commit) begin
          if (is_digit && (b_cnt_q != 2'd2)) begin
            b_d     = b_shift;
            b_cnt_d = b_cnt_q + 2'd1;
          end else if (is_op && (b_cnt_q == 2'd0)) begin
            op_d = key_sym;
          end else if (is_eq && (b_cnt_q != 2'd0)) begin
            res_d   = alu_res;
            neg_d   = (op_q == SYM_SUB) && (a_q < b_q);
            rv_d    = 1'b1;
            state_d = ST_RESULT;
          end
        end
      end
      ST_RESULT: begin
        if (commit) begin
          if (is_digit) begin
            a_d     = {4'b0000, key_val};
            a_cnt_d = 2'd1;
            b_d     = 8'h00;
            b_cnt_d = 2'd0;
            neg_d   = 1'b0;
            state_d = ST_ENTER_A;
          end else if (is_op) begin
            a_d     = res_q;
            a_cnt_d = 2'd2;
            op_d    = key_sym;
            b_d     = 8'h00;
            b_cnt_d = 2'd0;
            state_d = ST_ENTER_B;
          end
        end
      end
      default: begin
        a_d     = 8'h00;
        b_d     = 8'h00;
        a_cnt_d = 2'd0;
        b_cnt_d = 2'd0;
        neg_d   = 1'b0;
        state_d = ST_ENTER_A;
      end
    endcase
  end

  always_comb begin
    disp_val = a_q;
    case (state_q)
      ST_ENTER_A: disp_val = a_q;
      ST_ENTER_B: disp_val = (b_cnt_q != 2'd0) ? b_q : a_q;
      ST_RESULT:  disp_val = res_q;
      default:    disp_val = a_q;
    endcase
  end

  assign neg          = neg_q;
  assign result_valid = rv_q;
  assign state        = state_q;

endmodule

// File: doc/calc_entry_fsm.md
CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- key_down  in  1  key-pressed level from the keypad identifier (OR of row lines)
- key_val  in  4  registered digit code, 0-9
- key_sym  in  4  registered key class:
  - 1111 digit
  - 0001 add
  - 0010 sub
  - 0011 and
  - 0100 equals
  - 0101 cmp
  - 0110 or
  - 0000 none
- disp_val  out  8  value to display (binary)
- neg  out  1  result of last sub was negative
- result_valid  out  1  one-cycle pulse when a new result is latched
- state  out  2  current FSM state
  - 00 ENTER_A
  - 01 ENTER_B
  - 10 RESULT

Function
REQ-002 The block SHALL register key_down into key_down_d every cycle.
REQ-003 A key SHALL commit only in the release cycle (key_down_d=1, key_down=0), sampling key_val/key_sym in that same cycle; no other cycle commits a key.
REQ-004 The block SHALL ignore a commit whose key_sym is 0000 or any code not listed in REQ-001.
REQ-005 Committed-key effects SHALL be visible on outputs the cycle after the release cycle.
REQ-006 Operand entry:
- each operand is 8-bit with a 2-bit digit count (0-2)
- a digit updates operand = operand*10 + key_val and increments the count
- a digit arriving when the count is 2 is ignored
- key_val > 9 with sym 1111 is ignored
REQ-007 ENTER_A behaviour:
- digit: updates A
- operator (add/sub/and/or/cmp): stores op, clears B and its count, moves to ENTER_B; A=0 if no digits were entered
- equals: ignored
REQ-008 ENTER_B behaviour:
- digit: updates B
- operator with B count=0: replaces the stored op
- operator with B count>0: ignored
- equals with B count>0: computes and latches result, moves to RESULT
- equals with B count=0: ignored
REQ-009 RESULT behaviour:
- digit: starts a new calculation; A=key_val, A count=1, B cleared, neg=0, move to ENTER_A
- operator: chains; A=result, A count=2, op stored, B cleared, move to ENTER_B
- equals: ignored
REQ-010 Arithmetic, 8-bit result:
- add: A+B (max 198, no overflow)
- sub: (A-B) mod 256, neg=1 iff A<B
- and: A&B
- or: A|B
- cmp: 01 if A>B, 00 if A=B, FF if A<B
- neg SHALL be 0 for every op except sub
REQ-011 result_valid SHALL be high for exactly the one cycle after the equals commit that enters RESULT, and low at all other times.
REQ-012 disp_val selection:
- ENTER_A: A
- ENTER_B: B if B count>0, else A
- RESULT: result
REQ-013 The state encoding 11 SHALL be unreachable; if entered, the next cycle goes to ENTER_A with operands cleared.
REQ-014 A key held across many cycles SHALL commit exactly once; a glitch-free press shorter than one cycle is not required to commit.

Reset
REQ-015 While rst_n=0, the block SHALL immediately and asynchronously hold the following:
- state=ENTER_A
- A, B, result, op, digit counts, key_down_d all 0
- disp_val=00, neg=0, result_valid=0
REQ-016 Reset asserted mid-entry or mid-release SHALL discard the pending key.
REQ-017 After reset deasserts, the first commit SHALL occur only on a release whose press was observed after deassertion.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Keys 1,2,add,3,4,equals (each pressed 5 cycles, released): result_valid pulses once; disp_val=0x2E (46); state=10; neg=0.
- Keys 5,sub,7,equals: disp_val=0xFE, neg=1; then digit 9: state=00, disp_val=0x09, neg=0.
- Keys 1,2,3: third digit ignored, disp_val=0x0C; then equals in ENTER_A: no state change, result_valid stays 0.
- Keys 6,add,or,3,equals: op replaced, disp_val=0x07; then and,5,equals (chain): disp_val=0x05.
- Keys 4,cmp,4,equals gives 00; 3,cmp,4,equals gives FF; with key_down held 20 cycles, only one commit.
- Assert rst_n low during the key_down of digit 8 after entering 2,add: all outputs go 0 asynchronously; release after deassertion produces no commit.
